// File: rtl/arf_retire_sched.sv
// Retire-write scheduler: queues up to IN_W retiring results per cycle and drains
// them in order onto OUT_W ARF write ports, dropping r0 and coalescing same-dst pops.
module arf_retire_sched #(
  parameter int IN_W     = 4,
  parameter int OUT_W    = 2,
  parameter int DEPTH    = 16,
  parameter int AREG_NUM = 32,
  parameter int DATA_W   = 32
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [IN_W-1:0]                       in_valid,
  input  logic [IN_W*$clog2(AREG_NUM)-1:0]      in_dst,
  input  logic [IN_W*DATA_W-1:0]                in_data,
  output logic                                  in_ready,
  output logic [OUT_W-1:0]                      wr_en,
  output logic [OUT_W*$clog2(AREG_NUM)-1:0]     wr_addr,
  output logic [OUT_W*DATA_W-1:0]               wr_data,
  input  logic                                  drain_req,
  output logic                                  drain_done,
  output logic                                  busy,
  output logic [$clog2(DEPTH+1)-1:0]            count
);

  localparam int AW = $clog2(AREG_NUM);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [PW-1:0]            head_q, head_d;
  logic [PW-1:0]            tail_q, tail_d;
  logic [CW-1:0]            count_q, count_d;
  logic [OUT_W-1:0]         wr_en_q, wr_en_d;
  logic [OUT_W*AW-1:0]      wr_addr_q, wr_addr_d;
  logic [OUT_W*DATA_W-1:0]  wr_data_q, wr_data_d;

  logic [AW-1:0]            mem_dst  [DEPTH];
  logic [DATA_W-1:0]        mem_data [DEPTH];

  logic                     enq_fire;
  logic [IN_W-1:0]          keep;
  logic [PW-1:0]            slot_off [IN_W];
  logic [CW-1:0]            n_enq;
  logic [CW-1:0]            n_deq;
  logic [PW-1:0]            pop_idx  [OUT_W];
  logic [OUT_W-1:0]         pop_v;

  // Ready is judged on registered occupancy so it never depends on this cycle's pops.
  always_comb begin
    in_ready = !reset && (state_q == S_IDLE) && (count_q <= CW'(DEPTH - IN_W));
  end

  // Compaction: each kept slot lands at tail + (number of kept slots before it).
  always_comb begin
    enq_fire = in_ready && (|in_valid);
    n_enq    = '0;
    keep     = '0;
    for (int i = 0; i < IN_W; i++) begin
      slot_off[i] = n_enq[PW-1:0];
      keep[i]     = enq_fire && in_valid[i] && (in_dst[i*AW +: AW] != '0);
      if (keep[i]) begin
        n_enq = n_enq + CW'(1);
      end
    end
  end

  always_comb begin
    n_deq = (count_q < CW'(OUT_W)) ? count_q : CW'(OUT_W);
    for (int k = 0; k < OUT_W; k++) begin
      pop_idx[k] = head_q + PW'(k);
      pop_v[k]   = (CW'(k) < n_deq);
    end
  end

  // A popped entry is suppressed when a younger entry in the same group hits the same register.
  always_comb begin
    wr_en_d   = '0;
    wr_addr_d = '0;
    wr_data_d = '0;
    for (int k = 0; k < OUT_W; k++) begin
      wr_en_d[k] = pop_v[k];
      for (int j = k + 1; j < OUT_W; j++) begin
        if (pop_v[j] && (mem_dst[pop_idx[j]] == mem_dst[pop_idx[k]])) begin
          wr_en_d[k] = 1'b0;
        end
      end
      if (wr_en_d[k]) begin
        wr_addr_d[k*AW +: AW]         = mem_dst[pop_idx[k]];
        wr_data_d[k*DATA_W +: DATA_W] = mem_data[pop_idx[k]];
      end
    end
  end

  always_comb begin
    head_d  = head_q + n_deq[PW-1:0];
    tail_d  = tail_q + n_enq[PW-1:0];
    count_d = count_q + n_enq - n_deq;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (drain_req) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((count_q == '0) && (wr_en_q == '0)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Queue storage holds data only; validity is tracked entirely by head/count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < IN_W; i++) begin
      if (keep[i]) begin
        mem_dst[tail_q + slot_off[i]]  <= in_dst[i*AW +: AW];
        mem_data[tail_q + slot_off[i]] <= in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    wr_en      = wr_en_q;
    wr_addr    = wr_addr_q;
    wr_data    = wr_data_q;
    count      = count_q;
    drain_done = (state_q == S_DONE);
    busy       = (state_q != S_IDLE) || (count_q != '0);
  end

endmodule

// File: tb/tb_arf_retire_sched.sv
// Bench for arf_retire_sched: directed vector table, then randomized traffic
// checked cycle by cycle against a queue-based reference model.
module tb_arf_retire_sched;

  localparam int IN_W     = 4;
  localparam int OUT_W    = 2;
  localparam int DEPTH    = 16;
  localparam int AREG_NUM = 32;
  localparam int DATA_W   = 32;
  localparam int CW       = $clog2(DEPTH+1);

  logic                     clk = 1'b0;
  logic                     reset;
  logic [IN_W-1:0]          in_valid;
  logic [IN_W*5-1:0]        in_dst;
  logic [IN_W*DATA_W-1:0]   in_data;
  logic                     in_ready;
  logic [OUT_W-1:0]         wr_en;
  logic [OUT_W*5-1:0]       wr_addr;
  logic [OUT_W*DATA_W-1:0]  wr_data;
  logic                     drain_req;
  logic                     drain_done;
  logic                     busy;
  logic [CW-1:0]            count;

  always #5 clk = ~clk;

  arf_retire_sched #(
    .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .AREG_NUM(AREG_NUM), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_dst(in_dst), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .drain_req(drain_req), .drain_done(drain_done), .busy(busy), .count(count)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic             rst;
    logic             drain;
    logic [3:0]       vld;
    logic [3:0][4:0]  d;
    logic [31:0]      base;
    logic             e_rdy;
    int               e_cnt;
    logic [1:0]       e_en;
    logic [4:0]       e_a0, e_a1;
    logic [31:0]      e_x0, e_x1;
    logic             e_done, e_busy;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input int rst, input int drain, input int vld,
                              input int d0, input int d1, input int d2, input int d3,
                              input logic [31:0] base, input int rdy, input int cnt,
                              input int en, input int a0, input logic [31:0] x0,
                              input int a1, input logic [31:0] x1,
                              input int done, input int bsy);
    vec_t v;
    v.rst = 1'(rst); v.drain = 1'(drain); v.vld = 4'(vld);
    v.d[0] = 5'(d0); v.d[1] = 5'(d1); v.d[2] = 5'(d2); v.d[3] = 5'(d3);
    v.base = base; v.e_rdy = 1'(rdy); v.e_cnt = cnt; v.e_en = 2'(en);
    v.e_a0 = 5'(a0); v.e_x0 = x0; v.e_a1 = 5'(a1); v.e_x1 = x1;
    v.e_done = 1'(done); v.e_busy = 1'(bsy);
    return v;
  endfunction

  // Reference model: an in-order queue plus the drain state as a small integer.
  typedef struct packed {
    logic [4:0]  dst;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  int          mst;
  logic [1:0]  m_en;
  logic [4:0]  m_a[2];
  logic [31:0] m_x[2];

  task automatic model_step();
    ent_t pd[$];
    int   osz, n;
    logic oen, rdy, en;
    if (reset) begin
      mq.delete();
      mst = 0; m_en = '0;
      m_a[0] = '0; m_a[1] = '0; m_x[0] = '0; m_x[1] = '0;
    end else begin
      osz = mq.size();
      oen = |m_en;
      rdy = (mst == 0) && (DEPTH - osz >= IN_W);
      n   = (osz < OUT_W) ? osz : OUT_W;
      for (int k = 0; k < n; k++) pd.push_back(mq.pop_front());
      for (int k = 0; k < OUT_W; k++) begin
        en = (k < n);
        if (en) for (int j = k + 1; j < n; j++) if (pd[j].dst == pd[k].dst) en = 1'b0;
        m_en[k] = en;
        m_a[k]  = en ? pd[k].dst  : 5'd0;
        m_x[k]  = en ? pd[k].data : 32'd0;
      end
      if (rdy) begin
        for (int i = 0; i < IN_W; i++) begin
          if (in_valid[i] && in_dst[i*5 +: 5] != 5'd0)
            mq.push_back({in_dst[i*5 +: 5], in_data[i*DATA_W +: DATA_W]});
        end
      end
      case (mst)
        0: if (drain_req) mst = 1;
        1: if (osz == 0 && !oen) mst = 2;
        default: mst = 0;
      endcase
    end
  endtask

  task automatic cmp_model(input string tag);
    logic e_rdy;
    e_rdy = !reset && (mst == 0) && (DEPTH - mq.size() >= IN_W);
    chk({tag, " in_ready"}, 64'(in_ready), 64'(e_rdy));
    chk({tag, " count"}, 64'(count), 64'(mq.size()));
    chk({tag, " wr_en"}, 64'(wr_en), 64'(m_en));
    chk({tag, " wr_addr"}, 64'(wr_addr), 64'({m_a[1], m_a[0]}));
    chk({tag, " wr_data"}, 64'(wr_data), {m_x[1], m_x[0]});
    chk({tag, " drain_done"}, 64'(drain_done), 64'(mst == 2));
    chk({tag, " busy"}, 64'(busy), 64'((mst != 0) || (mq.size() != 0)));
    chk({tag, " one_write_per_addr"},
        64'(wr_en[0] && wr_en[1] && (wr_addr[4:0] == wr_addr[9:5])), 64'd0);
  endtask

  task automatic drive_rand(input bit full, input int p_drain, input int p_reset);
    int nv;
    nv = full ? IN_W : int'($urandom_range(0, IN_W));
    in_valid = 4'((1 << nv) - 1);
    for (int i = 0; i < IN_W; i++) begin
      in_dst[i*5 +: 5] = full ? 5'($urandom_range(1, 31)) : 5'($urandom_range(0, 7));
      in_data[i*DATA_W +: DATA_W] = $urandom;
    end
    drain_req = (p_drain != 0) && ($urandom_range(0, p_drain - 1) == 0);
    reset     = (p_reset != 0) && ($urandom_range(0, p_reset - 1) == 0);
  endtask

  initial begin
    reset = 1'b1; drain_req = 1'b0; in_valid = '0; in_dst = '0; in_data = '0;

    //        rst dr vld d0 d1 d2 d3 base          rdy cnt en a0 x0            a1 x1            dn bsy
    vt.push_back(mk(0, 0, 4'hF, 1, 2, 3, 4, 32'hA000_0000, 1, 0, 0, 0, 0,             0, 0,             0, 0));
    vt.push_back(mk(0, 0, 0,    0, 0, 0, 0, 0,             1, 4, 0, 0, 0,             0, 0,             0, 1));
    vt.push_back(mk(0, 0, 0,    0, 0, 0, 0, 0,             1, 2, 3, 1, 32'hA000_0000, 2, 32'hA000_0001, 0, 1));
    vt.push_back(mk(0, 0, 0,    0, 0, 0, 0, 0,             1, 0, 3, 3, 32'hA000_0002, 4, 32'hA000_0003, 0, 0));
    vt.push_back(mk(0, 0, 4'h7, 0, 5, 0, 0, 32'hB000_0000, 1, 0, 0, 0, 0,             0, 0,             0, 0));
    vt.push_back(mk(0, 0, 0,    0, 0, 0, 0, 0,             1, 1, 0, 0, 0,             0, 0,             0, 1));
    vt.push_back(mk(0, 0, 0,    0, 0, 0, 0, 0,             1, 0, 1, 5, 32'hB000_0001, 0, 0,             0, 0));
    vt.push_back(mk(0, 0, 4'hF, 7, 7, 8, 9, 32'hC000_0000, 1, 0, 0, 0, 0,             0, 0,             0, 0));
    vt.push_back(mk(0, 0, 0,    0, 0, 0, 0, 0,             1, 4, 0, 0, 0,             0, 0,             0, 1));
    vt.push_back(mk(0, 0, 0,    0, 0, 0, 0, 0,             1, 2, 2, 0, 0,             7, 32'hC000_0001, 0, 1));
    vt.push_back(mk(0, 0, 0,    0, 0, 0, 0, 0,             1, 0, 3, 8, 32'hC000_0002, 9, 32'hC000_0003, 0, 0));
    vt.push_back(mk(0, 0, 4'hF, 10, 11, 12, 13, 32'hD000_0000, 1, 0, 0, 0, 0,         0, 0,             0, 0));
    vt.push_back(mk(0, 0, 4'hF, 14, 15, 16, 17, 32'hE000_0000, 1, 4, 0, 0, 0,         0, 0,             0, 1));
    vt.push_back(mk(0, 1, 0,    0, 0, 0, 0, 0,             1, 6, 3, 10, 32'hD000_0000, 11, 32'hD000_0001, 0, 1));
    vt.push_back(mk(0, 0, 0,    0, 0, 0, 0, 0,             0, 4, 3, 12, 32'hD000_0002, 13, 32'hD000_0003, 0, 1));
    vt.push_back(mk(0, 0, 0,    0, 0, 0, 0, 0,             0, 2, 3, 14, 32'hE000_0000, 15, 32'hE000_0001, 0, 1));
    vt.push_back(mk(0, 0, 0,    0, 0, 0, 0, 0,             0, 0, 3, 16, 32'hE000_0002, 17, 32'hE000_0003, 0, 1));
    vt.push_back(mk(0, 0, 0,    0, 0, 0, 0, 0,             0, 0, 0, 0, 0,             0, 0,             0, 1));
    vt.push_back(mk(0, 0, 0,    0, 0, 0, 0, 0,             0, 0, 0, 0, 0,             0, 0,             1, 1));
    vt.push_back(mk(0, 1, 0,    0, 0, 0, 0, 0,             1, 0, 0, 0, 0,             0, 0,             0, 0));
    vt.push_back(mk(0, 0, 4'hF, 20, 21, 22, 23, 32'hF000_0000, 0, 0, 0, 0, 0,         0, 0,             0, 1));
    vt.push_back(mk(0, 0, 0,    0, 0, 0, 0, 0,             0, 0, 0, 0, 0,             0, 0,             1, 1));
    vt.push_back(mk(0, 0, 0,    0, 0, 0, 0, 0,             1, 0, 0, 0, 0,             0, 0,             0, 0));
    vt.push_back(mk(0, 0, 4'hF, 1, 2, 3, 4,     32'h1000_0000, 1, 0, 0, 0, 0,         0, 0,             0, 0));
    vt.push_back(mk(0, 0, 4'hF, 5, 6, 7, 8,     32'h2000_0000, 1, 4, 0, 0, 0,         0, 0,             0, 1));
    vt.push_back(mk(0, 0, 4'hF, 9, 10, 11, 12,  32'h3000_0000, 1, 6, 3, 1, 32'h1000_0000, 2, 32'h1000_0001, 0, 1));
    vt.push_back(mk(0, 1, 4'hF, 13, 14, 15, 16, 32'h4000_0000, 1, 8, 3, 3, 32'h1000_0002, 4, 32'h1000_0003, 0, 1));
    vt.push_back(mk(1, 1, 0,    0, 0, 0, 0, 0,             0, 10, 3, 5, 32'h2000_0000, 6, 32'h2000_0001, 0, 1));
    vt.push_back(mk(0, 0, 0,    0, 0, 0, 0, 0,             1, 0, 0, 0, 0,             0, 0,             0, 0));
    vt.push_back(mk(0, 0, 0,    0, 0, 0, 0, 0,             1, 0, 0, 0, 0,             0, 0,             0, 0));

    repeat (2) @(posedge clk);

    for (int r = 0; r < vt.size(); r++) begin
      @(negedge clk);
      reset     = vt[r].rst;
      drain_req = vt[r].drain;
      in_valid  = vt[r].vld;
      for (int i = 0; i < IN_W; i++) begin
        in_dst[i*5 +: 5]            = vt[r].d[i];
        in_data[i*DATA_W +: DATA_W] = vt[r].base + 32'(i);
      end
      #1;
      chk($sformatf("row%0d in_ready", r), 64'(in_ready), 64'(vt[r].e_rdy));
      chk($sformatf("row%0d count", r), 64'(count), 64'(vt[r].e_cnt));
      chk($sformatf("row%0d wr_en", r), 64'(wr_en), 64'(vt[r].e_en));
      chk($sformatf("row%0d wr_addr", r), 64'(wr_addr), 64'({vt[r].e_a1, vt[r].e_a0}));
      chk($sformatf("row%0d wr_data", r), 64'(wr_data), {vt[r].e_x1, vt[r].e_x0});
      chk($sformatf("row%0d drain_done", r), 64'(drain_done), 64'(vt[r].e_done));
      chk($sformatf("row%0d busy", r), 64'(busy), 64'(vt[r].e_busy));
    end

    @(negedge clk);
    reset = 1'b1; in_valid = '0; drain_req = 1'b0;
    @(posedge clk);
    model_step();

    // Back-to-back full bursts: occupancy saturates and the pointers wrap repeatedly.
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      drive_rand(1'b1, 0, 0);
      #1;
      cmp_model($sformatf("full%0d", c));
      @(posedge clk);
      model_step();
    end

    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      drive_rand(1'b0, 25, 150);
      #1;
      cmp_model($sformatf("rand%0d", c));
      @(posedge clk);
      model_step();
    end

    @(negedge clk);
    reset = 1'b0; in_valid = '0; drain_req = 1'b0;
    #1;
    cmp_model("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
